// File: rtl/ram1_data_port.sv
// ram1_data_port
//   Data-side bus master for the shared RAM1 / COM1 UART bus. Executes MEM-stage loads and
//   stores that target RAM1 (address < RAM1_UPPER) or the two COM1 registers, and holds busy
//   high so the pipeline stalls until the one-cycle done pulse.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   MemRead, MemWrite        load / store request (level); both set is a store
//   DM_Address, DM_WriteData request address and store data, captured when the access starts
//   DM_ReadData              last loaded value, updated as done rises
//   hit                      combinational: request targets RAM1 or COM1
//   busy, done               access in progress / one-cycle completion pulse
//   timeout                  sticky: a UART write never saw tbre&tsre
//   Ram1Addr, Ram1Data       RAM1 address and shared data bus
//   Ram1OE, Ram1WE, Ram1EN   active-low RAM1 strobes
//   rdn, wrn                 active-low UART strobes
//   data_ready, tbre, tsre   UART status inputs
module ram1_data_port #(
    parameter logic [15:0] RAM1_UPPER   = 16'h8000,
    parameter logic [15:0] COM1_DATA    = 16'hBF00,
    parameter logic [15:0] COM1_COMMAND = 16'hBF01,
    parameter int unsigned UART_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] DM_Address,
    input  logic [15:0] DM_WriteData,
    output logic [15:0] DM_ReadData,
    output logic        hit,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [17:0] Ram1Addr,
    inout  wire  [15:0] Ram1Data,
    output logic        Ram1OE,
    output logic        Ram1WE,
    output logic        Ram1EN,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    localparam int unsigned CntW = $clog2(UART_TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle,
        StRrd,
        StRwr1,
        StRwr2,
        StRwr3,
        StUrd,
        StSrd,
        StUwr1,
        StUwr2,
        StUwait,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [15:0]       r_addr;
    logic [15:0]       r_wdata;
    logic [15:0]       r_rdata;
    logic [CntW-1:0]   r_cnt;
    logic              r_timeout;

    logic              w_is_ram;
    logic              w_is_data;
    logic              w_is_cmd;
    logic              w_start;
    logic              w_uart_ready;
    logic              w_drive;
    logic [CntW-1:0]   w_cnt_inc;
    logic              w_cnt_expired;

    assign w_is_ram      = DM_Address < RAM1_UPPER;
    assign w_is_data     = DM_Address == COM1_DATA;
    assign w_is_cmd      = DM_Address == COM1_COMMAND;
    assign hit           = (MemRead | MemWrite) & (w_is_ram | w_is_data | w_is_cmd);
    assign w_start       = (r_state == StIdle) & hit;
    assign w_uart_ready  = tbre & tsre;
    assign w_cnt_inc     = r_cnt + CntW'(1);
    assign w_cnt_expired = w_cnt_inc >= CntW'(UART_TIMEOUT);

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (hit) begin
                    // A simultaneous read and write request is serviced as a write.
                    if (MemWrite) begin
                        if (w_is_ram)       w_state_next = StRwr1;
                        else if (w_is_data) w_state_next = StUwr1;
                        else                w_state_next = StDone;  // status reg is read-only
                    end else begin
                        if (w_is_ram)       w_state_next = StRrd;
                        else if (w_is_data) w_state_next = StUrd;
                        else                w_state_next = StSrd;
                    end
                end
            end
            StRrd:   w_state_next = StDone;
            StRwr1:  w_state_next = StRwr2;
            StRwr2:  w_state_next = StRwr3;
            StRwr3:  w_state_next = StDone;
            StUrd:   w_state_next = StDone;
            StSrd:   w_state_next = StDone;
            StUwr1:  w_state_next = StUwr2;
            StUwr2:  w_state_next = StUwait;
            StUwait: begin
                if (w_uart_ready || w_cnt_expired) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Moore outputs, so an asynchronous reset releases every strobe immediately.
    always_comb begin
        Ram1EN  = 1'b1;
        Ram1OE  = 1'b1;
        Ram1WE  = 1'b1;
        rdn     = 1'b1;
        wrn     = 1'b1;
        w_drive = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (r_state)
            StIdle: ;
            StRrd: begin
                busy   = 1'b1;
                Ram1EN = 1'b0;
                Ram1OE = 1'b0;
            end
            StRwr1, StRwr3: begin
                busy    = 1'b1;
                Ram1EN  = 1'b0;
                w_drive = 1'b1;
            end
            StRwr2: begin
                busy    = 1'b1;
                Ram1EN  = 1'b0;
                Ram1WE  = 1'b0;
                w_drive = 1'b1;
            end
            StUrd: begin
                busy = 1'b1;
                rdn  = 1'b0;
            end
            StSrd:   busy = 1'b1;
            StUwr1: begin
                busy    = 1'b1;
                wrn     = 1'b0;
                w_drive = 1'b1;
            end
            StUwr2: begin
                busy    = 1'b1;
                w_drive = 1'b1;
            end
            StUwait: busy = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_addr    <= 16'h0000;
            r_wdata   <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_addr  <= DM_Address;
                r_wdata <= DM_WriteData;
            end
            if (r_state == StRrd || r_state == StUrd) begin
                r_rdata <= Ram1Data;
            end
            if (r_state == StSrd) begin
                r_rdata <= {14'b0, data_ready, w_uart_ready};
            end
            if (r_state == StUwr2) begin
                r_cnt <= '0;
            end else if (r_state == StUwait) begin
                r_cnt <= w_cnt_inc;
                if (!w_uart_ready && w_cnt_expired) r_timeout <= 1'b1;
            end
        end
    end

    assign Ram1Data    = w_drive ? r_wdata : 16'hzzzz;
    assign Ram1Addr    = {2'b00, r_addr};
    assign DM_ReadData = r_rdata;
    assign timeout     = r_timeout;

endmodule
